frame_buffer_ctrl: RTL and testbench

Double-buffered 3-bit RGB frame buffer sitting directly upstream of the VGA scan-out stage. It accepts a pixel stream from the picture source over a valid/ready handshake and writes it into the back bank. It serves 1-cycle-latency reads of the front bank to the VGA stage. Banks swap only at a VGA frame boundary, and only after a complete frame has been written, so scan-out never shows a partially written picture.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/fb_bank_ram.sv | 34 +++
 rtl/frame_buffer_ctrl.sv | 161 ++++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA display constants and frame-buffer types.
// The frame-buffer blocks take these values as their parameter defaults.
package vga_pkg;

    localparam int H_DISP       = 800;
    localparam int V_DISP       = 600;
    localparam int FRAME_PIXELS = H_DISP * V_DISP;
    localparam int PIX_W        = 3;
    localparam int ADDR_W       = 19;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } fb_wr_state_e;

endpackage

// File: rtl/fb_bank_ram.sv
// One frame bank: a single write port plus a registered, enabled read port.
// It is coded so that synthesis can map it to block RAM.
module fb_bank_ram #(
    parameter int DEPTH  = vga_pkg::FRAME_PIXELS,
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int DATA_W = vga_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: neither the array nor the read register has a reset. A reset
    // would stop the array mapping to block RAM. The top level masks the
    // read register until the first valid read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame store between the picture source and VGA scan-out.
// The source fills the back bank, and the banks swap only at a frame boundary once a frame is complete.
module frame_buffer_ctrl #(
    parameter int H_DISP = vga_pkg::H_DISP,
    parameter int V_DISP = vga_pkg::V_DISP,
    parameter int PIX_W  = vga_pkg::PIX_W,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    input  logic [PIX_W-1:0]  i_pix_data,
    input  logic              i_pix_sof,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]  o_rd_data,
    input  logic              i_frame_end,
    output logic              o_rd_bank,
    output logic              o_swap,
    output logic              o_frame_ready
);

    import vga_pkg::*;

    localparam int                FRAME_PIX = H_DISP * V_DISP;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    fb_wr_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              pix_ready_q, pix_ready_d;
    logic              bank_q, bank_d;
    logic              swap_q, swap_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_oob_q, rd_oob_d;

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr;
    logic              rd_in_range;
    logic              rd_fetch;
    logic [PIX_W-1:0]  bank0_rdata, bank1_rdata;

    // Ready comes from a register that depends only on state, so it never depends on valid.
    assign accept = i_pix_valid && pix_ready_q;

    // NOTE: every signal assigned here gets its default value first. Then no
    // path through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        bank_d    = bank_q;
        swap_d    = 1'b0;
        wr_en     = 1'b0;
        wr_ptr    = wr_addr_q;

        case (state_q)
            IDLE: begin
                if (accept && i_pix_sof) begin
                    wr_en  = 1'b1;
                    wr_ptr = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_ptr = i_pix_sof ? '0 : wr_addr_q;
                end
            end
            FULL: begin
                if (i_frame_end) begin
                    bank_d    = ~bank_q;
                    swap_d    = 1'b1;
                    state_d   = IDLE;
                    wr_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start-of-frame pixel restarts the fill at address 0. The pixel written at the last address completes the frame.
        if (wr_en) begin
            wr_addr_d = wr_ptr + 1'b1;
            state_d   = (wr_ptr == LAST_ADDR) ? FULL : FILL;
        end

        pix_ready_d = (state_d != FULL);
    end

    assign rd_in_range = (i_rd_addr <= LAST_ADDR);
    assign rd_fetch    = i_rd_en && rd_in_range;

    // Capture which bank each read targets. A read in the swap cycle therefore returns the old picture.
    always_comb begin
        rd_sel_d = rd_sel_q;
        rd_oob_d = rd_oob_q;
        if (i_rd_en) begin
            rd_sel_d = bank_q;
            rd_oob_d = !rd_in_range;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Each flop
    // then samples values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            pix_ready_q <= 1'b0;
            bank_q      <= 1'b0;
            swap_q      <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_oob_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            pix_ready_q <= pix_ready_d;
            bank_q      <= bank_d;
            swap_q      <= swap_d;
            rd_sel_q    <= rd_sel_d;
            rd_oob_q    <= rd_oob_d;
        end
    end

    // Only the back bank (~bank_q) is written, so the displayed bank is never modified.
    fb_bank_ram #(
        .DEPTH (FRAME_PIX),
        .ADDR_W(ADDR_W),
        .DATA_W(PIX_W)
    ) u_bank0 (
        .clk    (clk),
        .i_we   (wr_en && bank_q),
        .i_waddr(wr_ptr),
        .i_wdata(i_pix_data),
        .i_re   (rd_fetch),
        .i_raddr(i_rd_addr),
        .o_rdata(bank0_rdata)
    );

    fb_bank_ram #(
        .DEPTH (FRAME_PIX),
        .ADDR_W(ADDR_W),
        .DATA_W(PIX_W)
    ) u_bank1 (
        .clk    (clk),
        .i_we   (wr_en && !bank_q),
        .i_waddr(wr_ptr),
        .i_wdata(i_pix_data),
        .i_re   (rd_fetch),
        .i_raddr(i_rd_addr),
        .o_rdata(bank1_rdata)
    );

    // An out-of-range read, or reset, forces the output to zero. This also hides the uninitialised read registers.
    assign o_rd_data     = rd_oob_q ? '0 : (rd_sel_q ? bank1_rdata : bank0_rdata);
    assign o_pix_ready   = pix_ready_q;
    assign o_rd_bank     = bank_q;
    assign o_swap        = swap_q;
    assign o_frame_ready = (state_q == FULL);

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl, built on a small 16x12 frame.
// A frame-level reference model supplies every expected output.
module tb_frame_buffer_ctrl;

    localparam int H     = 16;
    localparam int V     = 12;
    localparam int FRAME = H * V;
    localparam int PW    = 3;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pix_valid = 1'b0;
    logic          o_pix_ready;
    logic [PW-1:0] i_pix_data = '0;
    logic          i_pix_sof = 1'b0;
    logic          i_rd_en = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic [PW-1:0] o_rd_data;
    logic          i_frame_end = 1'b0;
    logic          o_rd_bank;
    logic          o_swap;
    logic          o_frame_ready;

    frame_buffer_ctrl #(.H_DISP(H), .V_DISP(V), .PIX_W(PW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .i_pix_data   (i_pix_data),
        .i_pix_sof    (i_pix_sof),
        .i_rd_en      (i_rd_en),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .i_frame_end  (i_frame_end),
        .o_rd_bank    (o_rd_bank),
        .o_swap       (o_swap),
        .o_frame_ready(o_frame_ready)
    );

    always #5 clk = ~clk;

    // Reference model: the picture held in each bank, plus frame bookkeeping.
    logic [PW-1:0] m_mem   [2][FRAME];
    bit            m_known [2][FRAME];
    bit            m_disp, m_started, m_full, m_ready, m_swap, m_rd_known;
    int            m_count;
    logic [PW-1:0] m_rd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        m_disp = 0; m_started = 0; m_full = 0; m_ready = 0; m_swap = 0;
        m_count = 0; m_rd = '0; m_rd_known = 1;
    endtask

    // Apply one cycle of stimulus. Update the model from the rules, then step past the edge.
    task automatic cycle(input bit valid, input logic [PW-1:0] data, input bit sof,
                         input bit rd_en, input int rd_addr, input bit fe);
        bit acc, full_pre;
        int idx, back;
        i_pix_valid = valid; i_pix_data = data; i_pix_sof = sof;
        i_rd_en = rd_en; i_rd_addr = AW'(rd_addr); i_frame_end = fe;
        full_pre = m_full;
        acc      = valid && m_ready;
        back     = m_disp ? 0 : 1;
        if (rd_en) begin
            if (rd_addr >= FRAME) begin
                m_rd = '0; m_rd_known = 1;
            end else begin
                m_rd = m_mem[m_disp][rd_addr]; m_rd_known = m_known[m_disp][rd_addr];
            end
        end
        if (acc && (sof || m_started)) begin
            idx = sof ? 0 : m_count;
            m_mem[back][idx] = data; m_known[back][idx] = 1;
            m_count = idx + 1; m_started = 1;
            if (m_count == FRAME) begin m_full = 1; m_started = 0; end
        end
        m_swap = fe && full_pre;
        if (m_swap) begin m_disp = !m_disp; m_full = 0; m_count = 0; end
        m_ready = !m_full;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        cycle(0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_pix_valid = 0; i_pix_sof = 0; i_rd_en = 0; i_frame_end = 0;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
    endtask

    // Feed pixels until n are accepted, with random valid gaps and random display reads.
    task automatic stream(input int n, input bit with_sof, input bit rand_data,
                          input logic [PW-1:0] sof_val, output int got);
        int budget;
        bit v, s;
        logic [PW-1:0] d;
        got = 0; budget = 0;
        while (got < n && budget < 8 * n + 50) begin
            v = ($urandom_range(0, 3) != 0);
            s = with_sof && (got == 0);
            if (s) d = sof_val;
            else if (rand_data) d = PW'($urandom);
            else d = PW'(m_count % 8);
            if (v && m_ready) got++;
            cycle(v, d, s, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0);
            budget++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (o_pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", o_pix_ready); end
        n_tests++; if (o_rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank got=%0b exp=0", o_rd_bank); end
        n_tests++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL reset_swap got=%0b exp=0", o_swap); end
        n_tests++; if (o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ready got=%0b exp=0", o_frame_ready); end
        n_tests++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got=%0d exp=0", o_rd_data); end
        idle_cycle();
        n_tests++; if (o_pix_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%0b exp=1", o_pix_ready); end
        cycle(0, '0, 0, 1, FRAME, 0);
        n_tests++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL reset_read_oob got=%0d exp=0", o_rd_data); end
    endtask

    task automatic test_first_frame();
        int got;
        stream(FRAME, 1, 0, '0, got);
        n_tests++; if (got !== FRAME) begin n_fail++; $display("FAIL fill_timeout got=%0d exp=%0d", got, FRAME); end
        n_tests++; if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL full_frame_ready got=%0b exp=1", o_frame_ready); end
        n_tests++; if (o_pix_ready !== 1'b0) begin n_fail++; $display("FAIL full_pix_ready got=%0b exp=0", o_pix_ready); end
        cycle(1, 3'd6, 0, 0, 0, 0);
        cycle(1, 3'd6, 1, 0, 0, 0);
        n_tests++; if (o_frame_ready !== 1'b1 || o_rd_bank !== 1'b0) begin n_fail++; $display("FAIL full_hold got=%0b/%0b exp=1/0", o_frame_ready, o_rd_bank); end
        cycle(0, '0, 0, 0, 0, 1);
        n_tests++; if (o_rd_bank !== 1'b1) begin n_fail++; $display("FAIL swap_bank got=%0b exp=1", o_rd_bank); end
        n_tests++; if (o_swap !== 1'b1) begin n_fail++; $display("FAIL swap_pulse got=%0b exp=1", o_swap); end
        idle_cycle();
        n_tests++; if (o_swap !== 1'b0) begin n_fail++; $display("FAIL swap_pulse_width got=%0b exp=0", o_swap); end
        n_tests++; if (o_pix_ready !== 1'b1 || o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL post_swap_idle got=%0b/%0b exp=1/0", o_pix_ready, o_frame_ready); end
        cycle(0, '0, 0, 1, 10, 0);
        n_tests++; if (o_rd_data !== 3'd2) begin n_fail++; $display("FAIL read_addr10 got=%0d exp=2", o_rd_data); end
        cycle(0, '0, 0, 1, FRAME - 1, 0);
        n_tests++; if (o_rd_data !== 3'd7) begin n_fail++; $display("FAIL read_last got=%0d exp=7", o_rd_data); end
    endtask

    task automatic test_discard_no_sof();
        int got;
        for (int i = 0; i < 5; i++) cycle(1, 3'd7, 0, 0, 0, 0);
        n_tests++; if (o_frame_ready !== 1'b0 || o_pix_ready !== 1'b1) begin n_fail++; $display("FAIL discard_state got=%0b/%0b exp=0/1", o_frame_ready, o_pix_ready); end
        stream(FRAME, 1, 1, 3'd4, got);
        n_tests++; if (got !== FRAME || o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL discard_fill got=%0d/%0b exp=%0d/1", got, o_frame_ready, FRAME); end
        cycle(0, '0, 0, 0, 0, 1);
        n_tests++; if (o_rd_bank !== 1'b0) begin n_fail++; $display("FAIL discard_swap got=%0b exp=0", o_rd_bank); end
        cycle(0, '0, 0, 1, 0, 0);
        n_tests++; if (o_rd_data !== 3'd4) begin n_fail++; $display("FAIL discard_addr0 got=%0d exp=4", o_rd_data); end
        for (int a = 1; a < 6; a++) begin
            cycle(0, '0, 0, 1, a, 0);
            n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL discard_addr%0d got=%0d exp=%0d", a, o_rd_data, m_rd); end
        end
    endtask

    task automatic test_midframe_sof();
        int got;
        stream(50, 1, 1, 3'd1, got);
        stream(FRAME - 1, 1, 1, 3'd5, got);
        n_tests++; if (o_frame_ready !== 1'b0 || o_pix_ready !== 1'b1) begin n_fail++; $display("FAIL restart_one_short got=%0b/%0b exp=0/1", o_frame_ready, o_pix_ready); end
        stream(1, 0, 1, '0, got);
        n_tests++; if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL restart_complete got=%0b exp=1", o_frame_ready); end
        cycle(0, '0, 0, 0, 0, 1);
        cycle(0, '0, 0, 1, 0, 0);
        n_tests++; if (o_rd_data !== 3'd5) begin n_fail++; $display("FAIL restart_addr0 got=%0d exp=5", o_rd_data); end
        cycle(0, '0, 0, 1, FRAME - 1, 0);
        n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL restart_last got=%0d exp=%0d", o_rd_data, m_rd); end
    endtask

    task automatic test_reset_midfill();
        int got;
        stream(20, 1, 1, 3'd3, got);
        do_reset();
        n_tests++; if (o_pix_ready !== 1'b0 || o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got=%0b/%0b exp=0/0", o_pix_ready, o_frame_ready); end
        n_tests++; if (o_rd_bank !== 1'b0 || o_swap !== 1'b0) begin n_fail++; $display("FAIL midreset_bank got=%0b/%0b exp=0/0", o_rd_bank, o_swap); end
        idle_cycle();
        for (int i = 0; i < 8; i++) begin
            cycle(0, '0, 0, 1, int'($urandom_range(0, FRAME - 1)), 0);
            n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL midreset_read got=%0d exp=%0d", o_rd_data, m_rd); end
        end
        // Pixels without sof must not resume the abandoned frame.
        for (int i = 0; i < 3; i++) cycle(1, 3'd6, 0, 0, 0, 0);
        n_tests++; if (m_started !== 1'b0 || o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_abandon got=%0b exp=0", o_frame_ready); end
    endtask

    task automatic test_frame_end_same_cycle();
        int  got, budget, addr;
        bit  v, s, fe;
        got = 0; budget = 0;
        while (got < FRAME && budget < 8 * FRAME) begin
            v    = ($urandom_range(0, 3) != 0);
            s    = (got == 0);
            fe   = v && (got == FRAME - 1);
            addr = int'($urandom_range(0, FRAME - 1));
            if (v && m_ready) got++;
            cycle(v, PW'($urandom), s, 1, addr, fe);
            budget++;
            if (m_rd_known) begin
                n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL display_during_fill addr=%0d got=%0d exp=%0d", addr, o_rd_data, m_rd); end
            end
        end
        n_tests++; if (got !== FRAME) begin n_fail++; $display("FAIL same_cycle_timeout got=%0d exp=%0d", got, FRAME); end
        n_tests++; if (o_rd_bank !== 1'b0 || o_swap !== 1'b0) begin n_fail++; $display("FAIL same_cycle_no_swap got=%0b/%0b exp=0/0", o_rd_bank, o_swap); end
        n_tests++; if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_full got=%0b exp=1", o_frame_ready); end
        addr = int'($urandom_range(0, FRAME - 1));
        cycle(0, '0, 0, 1, addr, 1);
        n_tests++; if (o_rd_bank !== 1'b1 || o_swap !== 1'b1) begin n_fail++; $display("FAIL same_cycle_next_swap got=%0b/%0b exp=1/1", o_rd_bank, o_swap); end
        n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL swap_cycle_old_bank got=%0d exp=%0d", o_rd_data, m_rd); end
        cycle(0, '0, 0, 1, addr, 0);
        n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL after_swap_new_bank got=%0d exp=%0d", o_rd_data, m_rd); end
    endtask

    task automatic test_oob_and_hold();
        cycle(0, '0, 0, 1, FRAME, 0);
        n_tests++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL oob_first got=%0d exp=0", o_rd_data); end
        cycle(0, '0, 0, 1, 255, 0);
        n_tests++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL oob_top got=%0d exp=0", o_rd_data); end
        for (int a = 0; a < FRAME; a++) begin
            if (m_mem[m_disp][a] != '0) begin
                cycle(0, '0, 0, 1, a, 0);
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, 0, 0, int'($urandom_range(0, 255)), 0);
            n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL read_hold got=%0d exp=%0d", o_rd_data, m_rd); end
        end
    endtask

    task automatic test_back_to_back();
        bit v, s, fe, re;
        for (int i = 0; i < 1500; i++) begin
            v  = ($urandom_range(0, 9) != 0);
            s  = m_started ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 1) == 0);
            fe = ($urandom_range(0, 19) == 0);
            re = bit'($urandom_range(0, 1));
            cycle(v, PW'($urandom), s, re, int'($urandom_range(0, 255)), fe);
            n_tests++; if (o_pix_ready !== m_ready || o_frame_ready !== m_full) begin n_fail++; $display("FAIL rand_flags cyc=%0d got=%0b/%0b exp=%0b/%0b", i, o_pix_ready, o_frame_ready, m_ready, m_full); end
            n_tests++; if (o_rd_bank !== m_disp || o_swap !== m_swap) begin n_fail++; $display("FAIL rand_bank cyc=%0d got=%0b/%0b exp=%0b/%0b", i, o_rd_bank, o_swap, m_disp, m_swap); end
            if (m_rd_known) begin
                n_tests++; if (o_rd_data !== m_rd) begin n_fail++; $display("FAIL rand_read cyc=%0d got=%0d exp=%0d", i, o_rd_data, m_rd); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < FRAME; a++) begin
                m_mem[b][a] = '0; m_known[b][a] = 0;
            end
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_first_frame();
        test_discard_no_sof();
        test_midframe_sof();
        test_reset_midfill();
        test_frame_end_same_cycle();
        test_oob_and_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
